load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits between the core's memory stage and the word-organised data RAM. The RAM has a word-indexed address, MemWrite, MemRead, 32-bit write_data, and a combinational read_data gated by MemRead.
- Converts RV32I byte-addressed load/store requests (LB, LH, LW, LBU, LHU, SB, SH, SW) into word accesses.
- Performs byte-lane extraction with sign or zero extension for loads.
- Performs read-modify-write for sub-word stores.
- Flags misaligned and illegal accesses.
- Uses a req/busy/done handshake with the core.

Parameters:
- address_width, 1024, number of 32-bit words in the attached RAM. The RAM word index is $clog2(address_width) bits.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous active-high reset.
- req  in  1  core request strobe. Sampled only in IDLE.
- store  in  1  1 = store, 0 = load.
- funct3  in  3  RV32I width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr  in  32  byte address.
- wdata  in  32  store data. Low byte or halfword is used for SB/SH.
- rdata  out  32  extended load result.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done: misaligned access or illegal funct3.
- MemWrite  out  1  RAM write enable.
- MemRead  out  1  RAM read enable.
- mem_address  out  $clog2(address_width)  RAM word index.
- mem_write_data  out  32  RAM write data.
- mem_read_data  in  32  RAM read data (combinational from RAM).

Behaviour:
- Reset (RST high at a rising edge):
  - State becomes IDLE.
  - rdata=0, done=0, err=0, busy=0.
  - Captured request registers are cleared.
  - MemWrite and MemRead are combinationally forced to 0 while RST is high, so no RAM write occurs on a reset edge.
  - Reset during any state aborts the operation. For an SB/SH in RMW_WR, RAM is left unmodified.
- Request capture:
  - In IDLE with req=1, the unit latches store, funct3, addr and wdata at the rising edge.
  - req while busy=1 is ignored and not queued.
- Word index: mem_address = addr_q[$clog2(address_width)+1:2]. Higher address bits are ignored, so addresses wrap modulo the RAM size.
- Alignment:
  - H/HU/SH with addr[0]=1 is misaligned.
  - W/SW with addr[1:0]≠00 is misaligned.
  - funct3 ∈ {011, 110, 111}, and store with funct3 ∈ {100, 101}, are illegal.
  - Misaligned or illegal: the unit goes to RESP with err=1. There is no RAM access and rdata is unchanged.
- FSM states: IDLE, LD, ST, RMW_RD, RMW_WR, RESP.
  - IDLE → CHECK (combinational on the captured request). Next state after capture: error → RESP; load → LD; SW → ST; SB/SH → RMW_RD.
  - LD:
    - MemRead=1.
    - Lane select: byte lane addr_q[1:0]; halfword lane addr_q[1].
    - Extension: LB/LH sign-extend, LBU/LHU zero-extend, LW passes the full word.
    - The result is registered into rdata at the edge.
    - Next state: RESP.
  - ST: MemWrite=1, mem_write_data=wdata_q. Next state: RESP.
  - RMW_RD: MemRead=1. mem_read_data is registered into merge_q. Next state: RMW_WR.
  - RMW_WR:
    - MemWrite=1.
    - mem_write_data = merge_q with the selected lane replaced: wdata_q[7:0] for SB, wdata_q[15:0] for SH. Other lanes are unchanged.
    - Next state: RESP.
  - RESP: done=1, err per check. Next state: IDLE.
- Signals outside their states:
  - MemRead and MemWrite are 0 outside LD/RMW_RD and ST/RMW_WR respectively.
  - They are never both high.
  - mem_write_data is 0 when MemWrite=0.
- Latency from the accepting edge to done high:
  - Loads and SW: 2 cycles.
  - SB/SH: 3 cycles.
  - Errors: 1 cycle.
  - A back-to-back req is accepted the cycle after RESP, when the unit is in IDLE.
- rdata holds its value until the next successful load completes. Stores and errors do not alter it.

Test Plan:
- Reset mid-operation: issue SB addr=0x8 wdata=0xAA over a word holding 0x11223344, and assert RST in RMW_WR → MemWrite stays 0, the word remains 0x11223344, busy=0 and done=0 the next cycle.
- Aligned SW then LW: SW addr=0x10 wdata=0xDEADBEEF → done 2 cycles later, err=0. LW addr=0x10 → rdata=0xDEADBEEF.
- Sub-word stores: word at 0x20 preloaded with 0x11223344. SB addr=0x21 wdata=0x000000AB → word 0x1122AB44, done 3 cycles after accept. Then SH addr=0x22 wdata=0xCAFE → word 0xCAFEAB44.
- Sign extension on word 0x80FF7F01 at 0x30:
  - LB 0x31 → 0x0000007F
  - LB 0x32 → 0xFFFFFFFF
  - LBU 0x32 → 0x000000FF
  - LH 0x32 → 0xFFFF80FF
  - LHU 0x32 → 0x000080FF
- Errors: LW addr=0x13, SH addr=0x21, funct3=011 → each gives done with err=1 one cycle after accept. MemRead and MemWrite never assert; rdata is unchanged.
- Handshake and wrap: req held high during an SB is ignored until IDLE. SW to byte address 4*address_width+4 writes word index 1.

Source files
------------

// File: rtl/load_store_unit.sv
// RV32I load/store unit: turns byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests
// into word RAM accesses, with lane extraction, sub-word read-modify-write and error flagging.
module load_store_unit #(
  parameter int address_width = 1024
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             req,
  input  logic                             store,
  input  logic [2:0]                       funct3,
  input  logic [31:0]                      addr,
  input  logic [31:0]                      wdata,
  output logic [31:0]                      rdata,
  output logic                             busy,
  output logic                             done,
  output logic                             err,
  output logic                             MemWrite,
  output logic                             MemRead,
  output logic [$clog2(address_width)-1:0] mem_address,
  output logic [31:0]                      mem_write_data,
  input  logic [31:0]                      mem_read_data
);

  localparam int AW = $clog2(address_width);

  typedef enum logic [2:0] {IDLE, LD, ST, RMW_RD, RMW_WR, RESP} state_t;

  state_t      state;
  logic        store_q;
  logic [2:0]  funct3_q;
  logic [AW+1:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] merge_q;
  logic        err_q;

  // Misaligned halfword/word, reserved funct3 codes, and unsigned-store codes are rejected.
  function automatic logic bad_access(input logic st, input logic [2:0] f3, input logic [1:0] a);
    logic r;
    case (f3)
      3'b000:  r = 1'b0;
      3'b001:  r = a[0];
      3'b010:  r = (a != 2'b00);
      3'b100:  r = st;
      3'b101:  r = st | a[0];
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] f3,
                                              input logic [1:0] lane);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = 32'(b);
      3'b001:  r = 32'(h);
      3'b100:  r = {24'b0, b};
      3'b101:  r = {16'b0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge_lane(input logic [31:0] word, input logic [31:0] wd,
                                             input logic [2:0] f3, input logic [1:0] lane);
    logic [31:0] r;
    r = word;
    if (f3[0]) r[{lane[1], 4'b0000} +: 16] = wd[15:0];
    else       r[{lane, 3'b000} +: 8]      = wd[7:0];
    return r;
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      rdata    <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      store_q  <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      merge_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: if (req) begin
          store_q  <= store;
          funct3_q <= funct3;
          addr_q   <= addr[AW+1:0];
          wdata_q  <= wdata;
          err_q    <= bad_access(store, funct3, addr[1:0]);
          if (bad_access(store, funct3, addr[1:0])) state <= RESP;
          else if (!store)                          state <= LD;
          else if (funct3[1])                       state <= ST;
          else                                      state <= RMW_RD;
        end
        LD: begin
          rdata <= load_extend(mem_read_data, funct3_q, addr_q[1:0]);
          state <= RESP;
        end
        ST:     state <= RESP;
        RMW_RD: begin
          merge_q <= mem_read_data;
          state   <= RMW_WR;
        end
        RMW_WR: state <= RESP;
        RESP: begin
          done  <= 1'b1;
          err   <= err_q;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM strobes are decoded from state but gated by reset so an aborted RMW never writes.
  assign busy        = (state != IDLE);
  assign MemRead     = !RST && (state == LD || state == RMW_RD);
  assign MemWrite    = !RST && (state == ST || state == RMW_WR);
  assign mem_address = addr_q[AW+1:2];

  always_comb begin
    mem_write_data = '0;
    if (MemWrite) begin
      if (state == ST) mem_write_data = wdata_q;
      else             mem_write_data = merge_lane(merge_q, wdata_q, funct3_q, addr_q[1:0]);
    end
  end

  logic unused_bits;
  assign unused_bits = ^{store_q, addr[31:AW+2]};

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a word RAM model and an expected-response queue.
module tb_load_store_unit;

  localparam int AWORDS = 1024;
  localparam int AW     = $clog2(AWORDS);

  logic          CLK = 1'b0;
  logic          RST;
  logic          req;
  logic          store;
  logic [2:0]    funct3;
  logic [31:0]   addr;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic          busy;
  logic          done;
  logic          err;
  logic          MemWrite;
  logic          MemRead;
  logic [AW-1:0] mem_address;
  logic [31:0]   mem_write_data;
  logic [31:0]   mem_read_data;

  logic [31:0] mem [0:AWORDS-1];

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  load_store_unit #(.address_width(AWORDS)) dut (
    .CLK(CLK), .RST(RST), .req(req), .store(store), .funct3(funct3), .addr(addr),
    .wdata(wdata), .rdata(rdata), .busy(busy), .done(done), .err(err),
    .MemWrite(MemWrite), .MemRead(MemRead), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) if (MemWrite) mem[mem_address] <= mem_write_data;
  assign mem_read_data = MemRead ? mem[mem_address] : 32'h0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, got, expv);
    end
  endtask

  task automatic do_op(input string tag, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic exp_err,
                       input logic [31:0] exp_rd, input int exp_lat, input bit hold);
    exp_t e;
    int   cyc;
    bit   act;
    @(negedge CLK);
    req = 1'b1; store = st; funct3 = f3; addr = a; wdata = wd;
    sb.push_back('{err: exp_err, rdata: exp_rd, lat: exp_lat});
    @(posedge CLK); #1;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    if (hold) begin
      store = 1'b1; funct3 = 3'b010; addr = 32'h40; wdata = 32'hBAD0BAD0;
    end else req = 1'b0;
    cyc = 0;
    act = 1'b0;
    while (!done && cyc < 20) begin
      chk({tag, "_excl"}, 32'(MemRead & MemWrite), 32'd0);
      if (!MemWrite) chk({tag, "_wd0"}, mem_write_data, 32'h0);
      act = act | MemRead | MemWrite;
      @(posedge CLK); #1;
      cyc++;
    end
    req = 1'b0;
    e = sb.pop_front();
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_lat"}, 32'(cyc), 32'(e.lat));
    chk({tag, "_err"}, 32'(err), 32'(e.err));
    chk({tag, "_rdata"}, rdata, e.rdata);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    if (e.err) chk({tag, "_noram"}, 32'(act), 32'd0);
  endtask

  initial begin
    RST = 1'b1; req = 1'b0; store = 1'b0; funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_memwr", 32'(MemWrite | MemRead), 32'd0);
    RST = 1'b0;

    // Abort an SB in RMW_WR: the preloaded word must survive.
    do_op("pre8", 1'b1, 3'b010, 32'h8, 32'h11223344, 1'b0, 32'h0, 2, 1'b0);
    @(negedge CLK);
    req = 1'b1; store = 1'b1; funct3 = 3'b000; addr = 32'h8; wdata = 32'hAA;
    @(posedge CLK); #1;
    req = 1'b0;
    @(posedge CLK); #1;
    chk("abort_in_rmw_wr", 32'(MemWrite), 32'd1);
    RST = 1'b1;
    #1;
    chk("abort_memwrite_gated", 32'(MemWrite), 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_word", mem[2], 32'h11223344);

    do_op("sw10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 2, 1'b0);
    do_op("lw10", 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 2, 1'b0);

    do_op("pre20", 1'b1, 3'b010, 32'h20, 32'h11223344, 1'b0, 32'hDEADBEEF, 2, 1'b0);
    do_op("sb21", 1'b1, 3'b000, 32'h21, 32'h000000AB, 1'b0, 32'hDEADBEEF, 3, 1'b0);
    chk("sb21_word", mem[8], 32'h1122AB44);
    do_op("sh22", 1'b1, 3'b001, 32'h22, 32'h0000CAFE, 1'b0, 32'hDEADBEEF, 3, 1'b0);
    chk("sh22_word", mem[8], 32'hCAFEAB44);
    do_op("lw20", 1'b0, 3'b010, 32'h20, 32'h0, 1'b0, 32'hCAFEAB44, 2, 1'b0);

    do_op("pre30", 1'b1, 3'b010, 32'h30, 32'h80FF7F01, 1'b0, 32'hCAFEAB44, 2, 1'b0);
    do_op("lb31", 1'b0, 3'b000, 32'h31, 32'h0, 1'b0, 32'h0000007F, 2, 1'b0);
    do_op("lb32", 1'b0, 3'b000, 32'h32, 32'h0, 1'b0, 32'hFFFFFFFF, 2, 1'b0);
    do_op("lbu32", 1'b0, 3'b100, 32'h32, 32'h0, 1'b0, 32'h000000FF, 2, 1'b0);
    do_op("lh32", 1'b0, 3'b001, 32'h32, 32'h0, 1'b0, 32'hFFFF80FF, 2, 1'b0);
    do_op("lhu32", 1'b0, 3'b101, 32'h32, 32'h0, 1'b0, 32'h000080FF, 2, 1'b0);
    do_op("lbu30", 1'b0, 3'b100, 32'h30, 32'h0, 1'b0, 32'h00000001, 2, 1'b0);

    do_op("err_lw13", 1'b0, 3'b010, 32'h13, 32'h0, 1'b1, 32'h00000001, 1, 1'b0);
    do_op("err_sh21", 1'b1, 3'b001, 32'h21, 32'h0000FFFF, 1'b1, 32'h00000001, 1, 1'b0);
    do_op("err_f011", 1'b0, 3'b011, 32'h20, 32'h0, 1'b1, 32'h00000001, 1, 1'b0);
    do_op("err_sbu", 1'b1, 3'b100, 32'h20, 32'h0, 1'b1, 32'h00000001, 1, 1'b0);
    chk("err_word_intact", mem[8], 32'hCAFEAB44);

    // req kept high during an SB with fields retargeted: nothing extra may be accepted.
    do_op("pre40", 1'b1, 3'b010, 32'h40, 32'h01234567, 1'b0, 32'h00000001, 2, 1'b0);
    do_op("sb43_hold", 1'b1, 3'b000, 32'h43, 32'h0000005A, 1'b0, 32'h00000001, 3, 1'b1);
    repeat (3) @(posedge CLK);
    #1;
    chk("hold_idle", 32'(busy), 32'd0);
    chk("hold_word", mem[16], 32'h5A234567);

    do_op("sw_wrap", 1'b1, 3'b010, 32'(4 * AWORDS + 4), 32'h13579BDF, 1'b0, 32'h00000001, 2, 1'b0);
    chk("wrap_word", mem[1], 32'h13579BDF);
    do_op("lw_wrap", 1'b0, 3'b010, 32'h4, 32'h0, 1'b0, 32'h13579BDF, 2, 1'b0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
